// File: rtl/prescale_ctrl.sv
// -----------------------------------------------------------------------------
// prescale_ctrl
//   Programmable power-of-two clock prescaler with a tick counter.
//   A configuration (scale, count) is accepted in IDLE. A start runs the
//   prescaler: every 2^scale source cycles a one-cycle tick is emitted and
//   clk_out toggles with 50% duty. Stop pauses (HOLD), a second stop aborts.
//   With a non-zero count the run ends with a done pulse on the count-th tick.
//
// Ports
//   clk_in     in   source clock
//   rst_n      in   asynchronous active-low reset
//   cfg_valid  in   configuration offer
//   cfg_ready  out  high in IDLE; handshake latches cfg_scale / cfg_count
//   cfg_scale  in   division exponent (clamped to 1..MAX_LOG2)
//   cfg_count  in   ticks to run, 0 = free-running
//   start      in   begin (IDLE) or resume (HOLD) counting
//   stop       in   pause (RUN) or abort (HOLD); wins over start
//   tick       out  one-cycle pulse at the end of each period
//   clk_out    out  registered divided clock
//   busy       out  high in RUN or HOLD
//   done       out  one-cycle pulse together with the count-th tick
// -----------------------------------------------------------------------------
module prescale_ctrl #(
    parameter int MAX_LOG2 = 26,
    parameter int CNT_W    = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [4:0]       cfg_scale,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    localparam logic [4:0]          MAX_SCALE = 5'(MAX_LOG2);
    localparam logic [MAX_LOG2-1:0] PH_ZERO   = {MAX_LOG2{1'b0}};
    localparam logic [MAX_LOG2-1:0] PH_ONES   = {MAX_LOG2{1'b1}};
    localparam logic [MAX_LOG2-1:0] PH_ONE    = MAX_LOG2'(1);
    localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

    // Keep the exponent inside 1..MAX_LOG2 so the half-period shift is valid.
    function automatic logic [4:0] clamp_scale(input logic [4:0] s);
        logic [4:0] r;
        if (s == 5'd0) begin
            r = 5'd1;
        end else if (s > MAX_SCALE) begin
            r = MAX_SCALE;
        end else begin
            r = s;
        end
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [MAX_LOG2-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [4:0]          scale_q, scale_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                clk_out_q, clk_out_d;

    logic [MAX_LOG2-1:0] term_s;
    logic [MAX_LOG2-1:0] half_s;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic                tick_s;
    logic                done_s;

    // Terminal phase 2^scale-1: shifting all-ones out at scale=MAX_LOG2 gives all-ones.
    assign term_s    = ~(PH_ONES << scale_q);
    assign half_s    = PH_ONE << (scale_q - 5'd1);
    assign cnt_inc_s = tick_cnt_q + CNT_ONE;

    // A stop in the terminal cycle swallows the tick (and any done) until resume.
    assign tick_s = (state_q == ST_RUN) && !stop && (phase_q == term_s);
    assign done_s = tick_s && (count_q != CNT_ZERO) && (cnt_inc_s == count_q);

    assign tick      = tick_s;
    assign done      = done_s;
    assign clk_out   = clk_out_q;
    assign busy      = (state_q != ST_IDLE);
    assign cfg_ready = (state_q == ST_IDLE);

    // Next-state and datapath update for the IDLE/RUN/HOLD controller.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        tick_cnt_d = tick_cnt_q;
        scale_d    = scale_q;
        count_d    = count_q;
        clk_out_d  = clk_out_q;
        case (state_q)
            ST_IDLE: begin
                phase_d    = PH_ZERO;
                tick_cnt_d = CNT_ZERO;
                clk_out_d  = 1'b0;
                if (cfg_valid) begin
                    scale_d = clamp_scale(cfg_scale);
                    count_d = cfg_count;
                end else begin
                    scale_d = scale_q;
                    count_d = count_q;
                end
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // clk_out follows the phase of the previous cycle.
                clk_out_d = (phase_q >= half_s);
                if (stop) begin
                    state_d = ST_HOLD;
                end else if (done_s) begin
                    state_d    = ST_IDLE;
                    phase_d    = PH_ZERO;
                    tick_cnt_d = CNT_ZERO;
                    clk_out_d  = 1'b0;
                end else if (tick_s) begin
                    phase_d    = PH_ZERO;
                    tick_cnt_d = cnt_inc_s;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d    = ST_IDLE;
                    phase_d    = PH_ZERO;
                    tick_cnt_d = CNT_ZERO;
                    clk_out_d  = 1'b0;
                end else if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                phase_d    = PH_ZERO;
                tick_cnt_d = CNT_ZERO;
                clk_out_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_ZERO;
            tick_cnt_q <= CNT_ZERO;
            scale_q    <= 5'd1;
            count_q    <= CNT_ZERO;
            clk_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tick_cnt_q <= tick_cnt_d;
            scale_q    <= scale_d;
            count_q    <= count_d;
            clk_out_q  <= clk_out_d;
        end
    end

endmodule
